cb_slave_mem: RTL and testbench

Slave-side endpoint that sits directly downstream of one crossbar slave port and consumes its request bus. It implements a word-addressed memory with a programmable number of wait states and returns ack and read data under the crossbar's slave handshake. It is used both as the on-chip scratch RAM and as the standard bench slave behind each crossbar port.

---
 rtl/cb_pkg.sv | 19 +
 rtl/cb_slave_mem_if.sv | 17 +
 rtl/cb_wait_counter.sv | 25 ++
 rtl/cb_slave_mem.sv | 116 +++++++++++
 tb/tb_cb_slave_mem.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/cb_pkg.sv
// rtl/cb_pkg.sv - shared crossbar definitions: command codes, FSM state encoding, defaults
package cb_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef logic [1:0] cb_state_t;
  localparam cb_state_t ST_IDLE = 2'd0;
  localparam cb_state_t ST_WAIT = 2'd1;
  localparam cb_state_t ST_ACK  = 2'd2;
  localparam cb_state_t ST_DATA = 2'd3;

  localparam logic [31:0] CB_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cb_slave_mem_if.sv
// rtl/cb_slave_mem_if.sv - crossbar slave-port request/response bus
interface cb_slave_mem_if #(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 32
);
  logic                 req;
  logic [ADDR_WDTH-1:0] addr;
  logic                 cmd;
  logic [DATA_WDTH-1:0] wdata;
  logic                 ack;
  logic [DATA_WDTH-1:0] rdata;
  logic                 busy;
  logic [7:0]           err_cnt;

  modport master (output req, addr, cmd, wdata, input ack, rdata, busy, err_cnt);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata, busy, err_cnt);
endinterface

// File: rtl/cb_wait_counter.sv
// rtl/cb_wait_counter.sv - 4-bit load/decrement counter with zero flag
module cb_wait_counter (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/cb_slave_mem.sv
// rtl/cb_slave_mem.sv - crossbar slave endpoint: word memory with programmable wait states
module cb_slave_mem
  import cb_pkg::*;
#(
  parameter int SLV_ID    = 0,
  parameter int SLV_NUM   = 2,
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 32,
  parameter int DEPTH     = 16,
  parameter int WAIT_CYC  = 2,
  parameter logic [DATA_WDTH-1:0] ERR_DATA = DATA_WDTH'(CB_ERR_DATA)
) (
  input  logic           i_clk,
  input  logic           rst,
  cb_slave_mem_if.slave  slv_bus
);

  localparam int SLV_AW = $clog2(SLV_NUM);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MID_W  = ADDR_WDTH - SLV_AW - IDX_W;
  // Counter holds remaining waits minus one, so the zero flag marks the last WAIT cycle.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  cb_state_t            state_q, state_d;
  logic [ADDR_WDTH-1:0] addr_q, addr_d;
  logic                 cmd_q, cmd_d;
  logic [DATA_WDTH-1:0] wdata_q, wdata_d;
  logic                 ack_q, busy_q;
  logic [DATA_WDTH-1:0] rdata_q, rdata_d;
  logic [7:0]           err_cnt_q;
  logic [DATA_WDTH-1:0] mem_q [DEPTH];
  logic                 accept, cnt_zero, in_range, in_ack;
  logic [IDX_W-1:0]     idx;

  assign accept   = slv_bus.req && ((state_q == ST_IDLE) || (state_q == ST_DATA));
  assign in_ack   = (state_q == ST_ACK);
  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (addr_q[ADDR_WDTH-1 -: SLV_AW] == SLV_AW'(SLV_ID)) &&
                    (addr_q[IDX_W +: MID_W] == '0);

  cb_wait_counter u_wait_cnt (
    .i_clk      (i_clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          addr_d  = slv_bus.addr;
          cmd_d   = slv_bus.cmd;
          wdata_d = slv_bus.wdata;
          state_d = (WAIT_CYC == 0) ? ST_ACK : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!slv_bus.req) state_d = ST_IDLE;
        else if (cnt_zero) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (in_ack && (cmd_q == CMD_READ)) rdata_d = in_range ? mem_q[idx] : ERR_DATA;
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cmd_q     <= CMD_READ;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      ack_q   <= (state_d == ST_ACK);
      busy_q  <= (state_d == ST_WAIT) || (state_d == ST_ACK);
      rdata_q <= rdata_d;
      if (in_ack && !in_range) err_cnt_q <= sat_inc8(err_cnt_q);
    end
  end

  // Synchronous clear on reset keeps this a plain register array.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (in_ack && (cmd_q == CMD_WRITE) && in_range) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign slv_bus.ack     = ack_q;
  assign slv_bus.busy    = busy_q;
  assign slv_bus.rdata   = rdata_q;
  assign slv_bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cb_slave_mem.sv
// tb/tb_cb_slave_mem.sv - randomized self-checking bench for cb_slave_mem
module tb_cb_slave_mem;
  import cb_pkg::*;

  logic i_clk = 1'b0;
  logic rst   = 1'b1;
  always #5 i_clk = ~i_clk;

  cb_slave_mem_if #(.DATA_WDTH(32), .ADDR_WDTH(32)) b2 ();
  cb_slave_mem_if #(.DATA_WDTH(32), .ADDR_WDTH(32)) b0 ();

  cb_slave_mem #(.SLV_ID(1), .SLV_NUM(2), .DATA_WDTH(32), .ADDR_WDTH(32), .DEPTH(16),
                 .WAIT_CYC(2), .ERR_DATA(32'hDEAD_BEEF))
    u_dut2 (.i_clk(i_clk), .rst(rst), .slv_bus(b2.slave));

  cb_slave_mem #(.SLV_ID(1), .SLV_NUM(2), .DATA_WDTH(32), .ADDR_WDTH(32), .DEPTH(16),
                 .WAIT_CYC(0), .ERR_DATA(32'hDEAD_BEEF))
    u_dut0 (.i_clk(i_clk), .rst(rst), .slv_bus(b0.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem2 [16];
  logic [31:0] mem0 [16];
  int err2 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a[31] == 1'b1) && ((a & 32'h7FFF_FFF0) == 32'h0);
  endfunction

  function automatic logic [31:0] oor_addr();
    if ($urandom_range(0, 1) == 0) return $urandom() & 32'h7FFF_FFFF;
    return 32'h8000_0000 | (32'($urandom_range(1, 1000)) << 4);
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One full transaction on the WAIT_CYC=2 instance; entered away from posedge.
  task automatic txn2(input logic cmd, input logic [31:0] addr, input logic [31:0] wd);
    int lat;
    logic [31:0] exp_rd;
    bit ok;
    ok     = in_rng(addr);
    exp_rd = (cmd == CMD_WRITE) ? 32'h0 : (ok ? mem2[addr[3:0]] : 32'hDEAD_BEEF);
    b2.req = 1'b1; b2.cmd = cmd; b2.addr = addr; b2.wdata = wd;
    @(posedge i_clk);
    #1 b2.wdata = ~wd;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) chk("busy_wait", 32'(b2.busy), 32'd1);
    end while (b2.ack !== 1'b1 && lat < 12);
    chk("ack_lat", lat, 3);
    b2.req = 1'b0;
    @(negedge i_clk);
    chk("ack_pulse", 32'(b2.ack), 32'd0);
    chk("rdata", b2.rdata, exp_rd);
    if (cmd == CMD_WRITE && ok) mem2[addr[3:0]] = wd;
    if (!ok) err2++;
    chk("err_cnt", 32'(b2.err_cnt), sat255(err2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a [8];
    logic [31:0] d [8];
    logic        c [8];
    logic [31:0] exp_rd, old7;
    int acks;

    for (int i = 0; i < 16; i++) begin mem2[i] = 32'h0; mem0[i] = 32'h0; end
    b2.req = 1'b0; b2.cmd = 1'b0; b2.addr = 32'h0; b2.wdata = 32'h0;
    b0.req = 1'b0; b0.cmd = 1'b0; b0.addr = 32'h0; b0.wdata = 32'h0;
    repeat (3) @(posedge i_clk);
    #1 rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ack",   32'(b2.ack), 32'd0);
    chk("rst_busy",  32'(b2.busy), 32'd0);
    chk("rst_rdata", b2.rdata, 32'h0);
    chk("rst_err",   32'(b2.err_cnt), 32'd0);
    chk("rst_ack0",  32'(b0.ack), 32'd0);
    chk("rst_rdata0", b0.rdata, 32'h0);

    // Zero-wait instance: four writes then four reads, re-requesting in every DATA cycle.
    for (int i = 0; i < 4; i++) begin
      c[i] = CMD_WRITE; a[i] = 32'h8000_0000 | 32'($urandom_range(0, 15)); d[i] = $urandom();
    end
    for (int i = 4; i < 8; i++) begin
      c[i] = CMD_READ; a[i] = a[$urandom_range(0, 3)]; d[i] = $urandom();
    end
    b0.req = 1'b1; b0.cmd = c[0]; b0.addr = a[0]; b0.wdata = d[0];
    @(posedge i_clk);
    for (int i = 0; i < 8; i++) begin
      exp_rd = (c[i] == CMD_READ) ? mem0[a[i][3:0]] : 32'h0;
      if (c[i] == CMD_WRITE) mem0[a[i][3:0]] = d[i];
      @(negedge i_clk);
      chk("b2b_ack",   32'(b0.ack), 32'd1);
      chk("b2b_busy",  32'(b0.busy), 32'd1);
      chk("b2b_rd0",   b0.rdata, 32'h0);
      if (i < 7) begin
        b0.cmd = c[i+1]; b0.addr = a[i+1]; b0.wdata = d[i+1];
      end else begin
        b0.req = 1'b0;
      end
      @(negedge i_clk);
      chk("b2b_noack", 32'(b0.ack), 32'd0);
      chk("b2b_idle",  32'(b0.busy), 32'd0);
      chk("b2b_rdata", b0.rdata, exp_rd);
    end

    txn2(CMD_WRITE, 32'h8000_0003, 32'hA5A5_0001);
    txn2(CMD_READ,  32'h8000_0003, 32'h0);

    // Out-of-range read and write; memory must not change.
    txn2(CMD_READ,  32'h8000_0010, 32'h0);
    txn2(CMD_WRITE, 32'h8000_0013, 32'h1234_5678);
    txn2(CMD_READ,  32'h8000_0003, 32'h0);
    txn2(CMD_READ,  32'h8000_0000, 32'h0);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ad;
      ad = ($urandom_range(0, 3) == 0) ? oor_addr() : (32'h8000_0000 | 32'($urandom_range(0, 15)));
      txn2(1'($urandom_range(0, 1)), ad, $urandom());
    end

    // Abort: request dropped in the second WAIT cycle.
    old7 = mem2[7];
    b2.req = 1'b1; b2.cmd = CMD_WRITE; b2.addr = 32'h8000_0007; b2.wdata = ~old7;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 b2.req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (b2.ack === 1'b1) acks++;
    end
    chk("abort_no_ack", acks, 0);
    chk("abort_err", 32'(b2.err_cnt), sat255(err2));
    txn2(CMD_READ, 32'h8000_0007, 32'h0);

    for (int i = 0; i < 300; i++) txn2(1'($urandom_range(0, 1)), oor_addr(), $urandom());
    chk("err_sat", 32'(b2.err_cnt), 32'd255);
    for (int i = 0; i < 4; i++) txn2(CMD_READ, 32'h8000_0000 | 32'($urandom_range(0, 15)), 32'h0);

    // Reset during the WAIT cycle of a write to index 5.
    txn2(CMD_WRITE, 32'h8000_0005, 32'h1111_2222);
    b2.req = 1'b1; b2.cmd = CMD_WRITE; b2.addr = 32'h8000_0005; b2.wdata = 32'hCAFE_F00D;
    @(posedge i_clk);
    #1 rst = 1'b1;
    @(negedge i_clk);
    chk("rst_mid_noack", 32'(b2.ack), 32'd0);
    @(posedge i_clk);
    #1 rst = 1'b0; b2.req = 1'b0;
    @(negedge i_clk);
    chk("rstm_ack",   32'(b2.ack), 32'd0);
    chk("rstm_busy",  32'(b2.busy), 32'd0);
    chk("rstm_rdata", b2.rdata, 32'h0);
    chk("rstm_err",   32'(b2.err_cnt), 32'd0);
    for (int i = 0; i < 16; i++) mem2[i] = 32'h0;
    err2 = 0;
    txn2(CMD_READ, 32'h8000_0005, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
